// File: rtl/pad_input_filter_pkg.sv
// Shared state encoding and default sizing for the pad input filter.
// Optional glitch counting is enabled by PAD_INPUT_FILTER_GLITCH_CNT_EN.
package pad_input_filter_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } chan_state_t;

  localparam int GLITCH_CNT_W    = 8;
  localparam int DEF_NPADS       = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pad_input_filter_chan.sv
// One pad channel: synchronizer, debounce FSM, edge detect and sticky event flag.
// PAD_INPUT_FILTER_GLITCH_CNT_EN adds a saturating per-pad abort counter.
module pad_input_filter_chan
  import pad_input_filter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pad,
  input  logic                    filter_en,
  input  logic [CNT_W-1:0]        debounce_cycles,
  input  logic                    rise_en,
  input  logic                    fall_en,
  input  logic                    event_clr,
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic                    level,
  output logic                    evt,
  output logic                    evt_next
);

  logic [SYNC_STAGES-1:0] sync;
  chan_state_t            state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   level_next;
  logic                   s, bypass, rise, fall;
  logic [CNT_W-1:0]       d_last;
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  logic                   abort;
`endif

  assign s      = sync[SYNC_STAGES-1];
  assign bypass = !filter_en || (debounce_cycles == '0);
  assign d_last = debounce_cycles - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pad};
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      evt   <= evt_next;
    end
  end

  // '>=' against D-1 lets a lowered D commit at once and keeps cnt from wrapping.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
    abort      = 1'b0;
`endif
    if (bypass) begin
      level_next = s;
      state_next = s ? STABLE_HI : STABLE_LO;
      cnt_next   = '0;
    end else begin
      case (state)
        STABLE_LO: if (s) begin
          state_next = PEND_HI;
          cnt_next   = '0;
        end
        STABLE_HI: if (!s) begin
          state_next = PEND_LO;
          cnt_next   = '0;
        end
        PEND_HI: begin
          if (!s) begin
            state_next = STABLE_LO;
            cnt_next   = '0;
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
            abort      = 1'b1;
`endif
          end else if (cnt >= d_last) begin
            level_next = 1'b1;
            state_next = STABLE_HI;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        PEND_LO: begin
          if (s) begin
            state_next = STABLE_HI;
            cnt_next   = '0;
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
            abort      = 1'b1;
`endif
          end else if (cnt >= d_last) begin
            level_next = 1'b0;
            state_next = STABLE_LO;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = STABLE_LO;
      endcase
    end
  end

  assign rise     = level_next & ~level;
  assign fall     = ~level_next & level;
  assign evt_next = (rise & rise_en) | (fall & fall_en) | (evt & ~event_clr);

`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  // Clear has priority, so an abort in the clearing cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/pad_input_filter.sv
// Receive-side pad conditioning: NPADS filter channels plus a shared IRQ register.
// Define PAD_INPUT_FILTER_GLITCH_CNT_EN to expose glitch_clr_i / glitch_cnt_o.
module pad_input_filter
  import pad_input_filter_pkg::*;
#(
  parameter int NPADS       = DEF_NPADS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NPADS-1:0]              pad_in_i,
  input  logic [NPADS-1:0]              filter_en_i,
  input  logic [CNT_W-1:0]              debounce_cycles_i,
  input  logic [NPADS-1:0]              rise_en_i,
  input  logic [NPADS-1:0]              fall_en_i,
  input  logic [NPADS-1:0]              event_clr_i,
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
  input  logic [NPADS-1:0]              glitch_clr_i,
  output logic [NPADS*GLITCH_CNT_W-1:0] glitch_cnt_o,
`endif
  output logic [NPADS-1:0]              level_o,
  output logic [NPADS-1:0]              event_o,
  output logic                          irq_o
);

  logic [NPADS-1:0] evt_next;

  for (genvar i = 0; i < NPADS; i++) begin : g_chan
    pad_input_filter_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk             (clk_i),
      .rst             (rst_i),
      .pad             (pad_in_i[i]),
      .filter_en       (filter_en_i[i]),
      .debounce_cycles (debounce_cycles_i),
      .rise_en         (rise_en_i[i]),
      .fall_en         (fall_en_i[i]),
      .event_clr       (event_clr_i[i]),
`ifdef PAD_INPUT_FILTER_GLITCH_CNT_EN
      .glitch_clr      (glitch_clr_i[i]),
      .glitch_cnt      (glitch_cnt_o[i*GLITCH_CNT_W +: GLITCH_CNT_W]),
`endif
      .level           (level_o[i]),
      .evt             (event_o[i]),
      .evt_next        (evt_next[i])
    );
  end

  // Built from the next-state flags so irq_o rises together with event_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |evt_next;
    end
  end

endmodule
